div_module: RTL
===============

DIV_MODULE -- requirements
Module: div_module

Interface
REQ-001 Parameters: none; all widths fixed, with a 5-bit dividend matching the registered 4+4 adder sum width.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request; sampled only while idle.
REQ-005 dividend  input  5  unsigned dividend; sampled with an accepted start.
REQ-006 divisor  input  4  unsigned divisor; sampled with an accepted start.
REQ-007 quotient  output  5  registered unsigned quotient.
REQ-008 remainder  output  4  registered unsigned remainder.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse; quotient and remainder are valid.
REQ-011 div_by_zero  output  1  registered flag for the last completed operation.

Function
REQ-012 The block SHALL be a restoring shift-subtract divider with FSM states IDLE, BUSY and ZERO.
REQ-013 IDLE with start=1 at edge k: the block SHALL capture dividend and divisor, and clear div_by_zero.
REQ-014 At edge k, if divisor!=0, the FSM SHALL go to BUSY with an iteration counter of 0 and busy=1.
REQ-015 At edge k, if divisor==0, the FSM SHALL go to ZERO with busy=1.
REQ-016 BUSY: each edge SHALL shift the 5-bit partial remainder left by one and bring in the next dividend bit, MSB first.
REQ-017 BUSY: on each such edge, if the partial remainder >= divisor, the block SHALL subtract the divisor and set quotient bit 1; otherwise quotient bit 0.
REQ-018 The partial remainder SHALL be 5 bits wide internally, and the subtraction SHALL never underflow.
REQ-019 Exactly 5 iterations SHALL occur, at edges k+1 through k+5.
REQ-020 At edge k+5: quotient and remainder SHALL update, done=1 and busy=0 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-021 ZERO at edge k+1: the block SHALL set quotient=5'h1F, remainder=dividend[3:0], div_by_zero=1, done=1 and busy=0, then return to IDLE.
REQ-022 start SHALL be ignored while busy=1; operands captured at acceptance SHALL be immune to later input changes.
REQ-023 start=1 during the done cycle SHALL be accepted (the FSM is IDLE); done SHALL fall on that edge and the next result SHALL follow 5 edges later, or 1 edge later for a zero divisor.
REQ-024 quotient, remainder and div_by_zero SHALL hold their last values until the next completion; intermediate iterations SHALL NOT be visible on these outputs.
REQ-025 Invariant for every non-zero divisor: quotient*divisor + remainder == dividend, and remainder < divisor.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, with quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, and the counter and internal registers cleared.
REQ-027 Reset asserted mid-operation SHALL abort the division with no done pulse; after release, the first start SHALL behave as from power-up.
REQ-028 start coincident with rst=1 SHALL be ignored.

Verification
REQ-029 dividend=23, divisor=5, start for 1 cycle -> busy for 5 cycles, then done pulse with quotient=4, remainder=3, div_by_zero=0.
REQ-030 31/1 -> quotient=31, remainder=0; 3/15 -> quotient=0, remainder=3; 0/7 -> quotient=0, remainder=0; each done exactly 5 edges after acceptance.
REQ-031 dividend=7, divisor=0 -> done one edge after acceptance with quotient=31, remainder=7, div_by_zero=1; a following 10/3 -> quotient=3, remainder=1, div_by_zero=0.
REQ-032 Start 20/6, then change the inputs and pulse start while busy -> result quotient=3, remainder=2, only one done pulse.
REQ-033 Start 25/4, then assert rst at iteration 3 -> outputs zero at once, no done pulse; after release, 9/2 -> quotient=4, remainder=1.
REQ-034 Back-to-back runs, with start held high through the done cycle -> consecutive done pulses 6 cycles apart; exhaustive sweep of all 512 operand pairs against a reference model, all matching REQ-025 and REQ-021.

Source files
------------

// File: rtl/div_module.sv
// -----------------------------------------------------------------------------
// div_module
//   Restoring shift-subtract divider: 5-bit unsigned dividend by 4-bit unsigned
//   divisor. A non-zero divisor produces its result five clock edges after the
//   start is accepted. A zero divisor produces a saturated quotient one edge
//   after acceptance.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   start        request, sampled only while idle
//   dividend     5-bit unsigned dividend, captured with an accepted start
//   divisor      4-bit unsigned divisor, captured with an accepted start
//   quotient     registered 5-bit quotient (holds until the next completion)
//   remainder    registered 4-bit remainder (holds until the next completion)
//   busy         high while a division is in progress
//   done         one-cycle pulse, quotient/remainder/div_by_zero are valid
//   div_by_zero  registered flag for the last completed operation
// -----------------------------------------------------------------------------
module div_module (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] dividend,
  input  logic [3:0] divisor,
  output logic [4:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t     state, state_nxt;

  // dvd_sh is the captured dividend; it shifts left once per iteration so its
  // MSB is always the next dividend bit to bring into the partial remainder.
  logic [4:0] dvd_sh, dvd_sh_nxt;
  logic [3:0] dvs, dvs_nxt;
  logic [4:0] rem_p, rem_p_nxt;
  logic [4:0] quo_p, quo_p_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic [4:0] quotient_nxt;
  logic [3:0] remainder_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic       div_by_zero_nxt;

  logic [5:0] step;
  logic       step_qbit;
  logic [4:0] step_rem;

  // One restoring iteration: shift the partial remainder left, bring in the
  // next dividend bit and subtract the divisor when it fits. Returns
  // {quotient_bit, new_partial_remainder}. The partial remainder entering an
  // iteration is always below the divisor (<= 14), so its MSB is zero and the
  // bit shifted out carries no information; the compare guards the subtract,
  // so it can never underflow.
  function automatic logic [5:0] restore_step(input logic [4:0] rem,
                                              input logic       in_bit,
                                              input logic [3:0] dvs_in);
    logic [4:0] sh;
    logic [4:0] dvs_ext;
    sh      = {rem[3:0], in_bit};
    dvs_ext = {1'b0, dvs_in};
    if (sh >= dvs_ext) begin
      return {1'b1, sh - dvs_ext};
    end
    return {1'b0, sh};
  endfunction

  assign step      = restore_step(rem_p, dvd_sh[4], dvs);
  assign step_qbit = step[5];
  assign step_rem  = step[4:0];

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt       = state;
    dvd_sh_nxt      = dvd_sh;
    dvs_nxt         = dvs;
    rem_p_nxt       = rem_p;
    quo_p_nxt       = quo_p;
    cnt_nxt         = cnt;
    quotient_nxt    = quotient;
    remainder_nxt   = remainder;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    div_by_zero_nxt = div_by_zero;

    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          dvd_sh_nxt      = dividend;
          dvs_nxt         = divisor;
          rem_p_nxt       = 5'd0;
          quo_p_nxt       = 5'd0;
          cnt_nxt         = 3'd0;
          div_by_zero_nxt = 1'b0;
          busy_nxt        = 1'b1;
          state_nxt       = (divisor == 4'd0) ? ZERO : BUSY;
        end
      end

      BUSY: begin
        dvd_sh_nxt = {dvd_sh[3:0], 1'b0};
        rem_p_nxt  = step_rem;
        quo_p_nxt  = {quo_p[3:0], step_qbit};
        cnt_nxt    = cnt + 3'd1;
        // The fifth iteration publishes straight from the step result so the
        // outputs only ever change on completion.
        if (cnt == 3'd4) begin
          quotient_nxt  = {quo_p[3:0], step_qbit};
          remainder_nxt = step_rem[3:0];
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          cnt_nxt       = 3'd0;
          state_nxt     = IDLE;
        end
      end

      ZERO: begin
        quotient_nxt    = 5'h1F;
        remainder_nxt   = dvd_sh[3:0];
        div_by_zero_nxt = 1'b1;
        done_nxt        = 1'b1;
        busy_nxt        = 1'b0;
        state_nxt       = IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd_sh      <= 5'd0;
      dvs         <= 4'd0;
      rem_p       <= 5'd0;
      quo_p       <= 5'd0;
      cnt         <= 3'd0;
      quotient    <= 5'd0;
      remainder   <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      dvd_sh      <= dvd_sh_nxt;
      dvs         <= dvs_nxt;
      rem_p       <= rem_p_nxt;
      quo_p       <= quo_p_nxt;
      cnt         <= cnt_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      div_by_zero <= div_by_zero_nxt;
    end
  end

endmodule
